// File: rtl/cfu_pkg.sv
// Shared CFU-L2 definitions: response status encoding and the buffered response record.
package cfu_pkg;

  localparam int CFU_PKG_STATUS_W = 3;
  localparam int CFU_PKG_DATA_W   = 32;

  typedef enum logic [CFU_PKG_STATUS_W-1:0] {
    CFU_OK           = 3'd0,
    CFU_ERROR_CFU    = 3'd1,
    CFU_ERROR_OFF    = 3'd2,
    CFU_ERROR_STATE  = 3'd3,
    CFU_ERROR_CUSTOM = 3'd4
  } cfu_status_e;

  // Field order matches the {status, data} packing used by the response FIFO.
  typedef struct packed {
    logic [CFU_PKG_STATUS_W-1:0] status;
    logic [CFU_PKG_DATA_W-1:0]   data;
  } cfu_resp_t;

endpackage

// File: rtl/cfu_resp_fifo.sv
// Registered response FIFO, DEPTH a power of two; pointers wrap naturally.
module cfu_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_pop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clk_en) begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && push) mem[wr_ptr] <= wdata;
  end

  // Credit accounting upstream must keep a slot free for every outstanding request.
  assert property (@(posedge clk) disable iff (!rst_n) (clk_en && push) |-> !full);

endmodule

// File: rtl/cfu_l2_initiator.sv
// CFU-L2 initiator: one-entry registered request stage, credit counter and in-order response buffer.
module cfu_l2_initiator
  import cfu_pkg::*;
#(
  parameter int CFU_CFU_ID_W  = 1,
  parameter int CFU_FUNC_ID_W = 10,
  parameter int CFU_DATA_W    = CFU_PKG_DATA_W,
  parameter int CFU_STATUS_W  = CFU_PKG_STATUS_W,
  parameter int MAX_OUT       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [CFU_CFU_ID_W-1:0]    cmd_cfu,
  input  logic [CFU_FUNC_ID_W-1:0]   cmd_func,
  input  logic [CFU_DATA_W-1:0]      cmd_data0,
  input  logic [CFU_DATA_W-1:0]      cmd_data1,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [CFU_CFU_ID_W-1:0]    req_cfu,
  output logic [CFU_FUNC_ID_W-1:0]   req_func,
  output logic [CFU_DATA_W-1:0]      req_data0,
  output logic [CFU_DATA_W-1:0]      req_data1,
  input  logic                       resp_valid,
  output logic                       resp_ready,
  input  logic [CFU_STATUS_W-1:0]    resp_status,
  input  logic [CFU_DATA_W-1:0]      resp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CFU_STATUS_W-1:0]    out_status,
  output logic [CFU_DATA_W-1:0]      out_data,
  output logic [$clog2(MAX_OUT):0]   in_flight,
  output logic                       err_unexp
);

  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int W  = CFU_STATUS_W + CFU_DATA_W;

  logic [CW-1:0] pending;
  logic          credit_ok;
  logic          out_pop;
  logic          cmd_fire;
  logic          req_fire;
  logic          resp_take;
  logic          resp_unexp;
  logic          fifo_empty;
  logic [W-1:0]  fifo_rdata;

  // A pop in the same cycle frees a credit, so a full initiator can accept immediately.
  assign out_pop    = out_valid && out_ready;
  assign credit_ok  = (in_flight < CW'(MAX_OUT)) || out_pop;
  assign cmd_ready  = rst_n && credit_ok && (!req_valid || req_ready);
  assign cmd_fire   = clk_en && cmd_valid && cmd_ready;
  assign req_fire   = clk_en && req_valid && req_ready;
  assign resp_take  = clk_en && resp_valid && resp_ready && (pending != '0);
  assign resp_unexp = clk_en && resp_valid && resp_ready && (pending == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req_cfu   <= '0;
      req_func  <= '0;
      req_data0 <= '0;
      req_data1 <= '0;
    end else if (cmd_fire) begin
      req_valid <= 1'b1;
      req_cfu   <= cmd_cfu;
      req_func  <= cmd_func;
      req_data0 <= cmd_data0;
      req_data1 <= cmd_data1;
    end else if (req_fire) begin
      req_valid <= 1'b0;
    end
  end

  // pending counts requests issued on L2 but not yet answered; in_flight spans cmd accept to host pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_ready <= 1'b0;
      err_unexp  <= 1'b0;
      pending    <= '0;
      in_flight  <= '0;
    end else if (clk_en) begin
      resp_ready <= 1'b1;
      if (resp_unexp) err_unexp <= 1'b1;
      pending   <= pending + CW'(req_fire) - CW'(resp_take);
      in_flight <= in_flight + CW'(cmd_fire) - CW'(out_pop);
    end
  end

  cfu_resp_fifo #(
    .DEPTH (MAX_OUT),
    .W     (W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .push   (resp_take),
    .wdata  ({resp_status, resp_data}),
    .pop    (out_pop),
    .rdata  (fifo_rdata),
    .empty  (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_status = fifo_rdata[W-1:CFU_DATA_W];
  assign out_data   = fifo_rdata[CFU_DATA_W-1:0];

endmodule

// File: tb/tb_cfu_l2_initiator.sv
// Scenario bench for cfu_l2_initiator: scripted host, auto-responder and an in-order scoreboard.
module tb_cfu_l2_initiator;
  import cfu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clk_en;
  logic        cmd_valid, cmd_ready;
  logic        cmd_cfu;
  logic [9:0]  cmd_func;
  logic [31:0] cmd_data0, cmd_data1;
  logic        req_valid, req_ready;
  logic        req_cfu;
  logic [9:0]  req_func;
  logic [31:0] req_data0, req_data1;
  logic        resp_valid, resp_ready;
  logic [2:0]  resp_status;
  logic [31:0] resp_data;
  logic        out_valid, out_ready;
  logic [2:0]  out_status;
  logic [31:0] out_data;
  logic [2:0]  in_flight;
  logic        err_unexp;

  logic        auto_valid, man_valid;
  logic [2:0]  auto_status, man_status;
  logic [31:0] auto_data, man_data;

  cfu_resp_t sb_q[$];
  cfu_resp_t rsp_q[$];
  int checks = 0;
  int errors = 0;
  int req_seen = 0;

  always #5 clk = ~clk;

  assign resp_valid  = auto_valid | man_valid;
  assign resp_status = man_valid ? man_status : auto_status;
  assign resp_data   = man_valid ? man_data : auto_data;

  cfu_l2_initiator #(
    .CFU_CFU_ID_W(1), .CFU_FUNC_ID_W(10), .CFU_DATA_W(32), .CFU_STATUS_W(3), .MAX_OUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cfu(cmd_cfu), .cmd_func(cmd_func),
    .cmd_data0(cmd_data0), .cmd_data1(cmd_data1),
    .req_valid(req_valid), .req_ready(req_ready), .req_cfu(req_cfu), .req_func(req_func),
    .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_status(out_status), .out_data(out_data),
    .in_flight(in_flight), .err_unexp(err_unexp)
  );

  // Responder behaviour: func 9 reports a custom error, otherwise OK with a field-dependent result.
  function automatic cfu_resp_t resp_fn(input logic cfu, input logic [9:0] func,
                                        input logic [31:0] d0, input logic [31:0] d1);
    cfu_resp_t r;
    r.status = (func == 10'd9) ? CFU_ERROR_CUSTOM : CFU_OK;
    r.data   = d0 + d1 + (32'(func) << 8) - 32'd768 + (32'(cfu) << 31);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && clk_en && req_valid && req_ready) begin
      rsp_q.push_back(resp_fn(req_cfu, req_func, req_data0, req_data1));
      req_seen++;
    end
  end

  // Answers each accepted request exactly one cycle after its handshake.
  always @(posedge clk) begin
    cfu_resp_t r;
    #1;
    if (!rst_n) begin
      rsp_q.delete();
      auto_valid = 1'b0;
    end else if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      auto_valid  = 1'b1;
      auto_status = r.status;
      auto_data   = r.data;
    end else begin
      auto_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    cfu_resp_t e;
    if (rst_n && clk_en && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL out_extra: got status %0d data %h, nothing expected", out_status, out_data);
      end else begin
        e = sb_q.pop_front();
        if (out_status !== e.status || out_data !== e.data) begin
          errors++;
          $display("[TB] FAIL out_order: got status %0d data %h, want status %0d data %h",
                   out_status, out_data, e.status, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_cmd(input logic cfu, input logic [9:0] func, input logic [31:0] d0,
                           input logic [31:0] d1, input int budget);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_cfu = cfu; cmd_func = func; cmd_data0 = d0; cmd_data1 = d1;
    for (int n = 0; n < budget; n++) begin
      #1;
      if (cmd_ready) begin
        ok = 1;
        sb_q.push_back(resp_fn(cfu, func, d0, d1));
      end
      tick();
      if (ok) break;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL cmd_accept: got no cmd_ready in %0d cycles, want accept", budget); end
  endtask

  task automatic wait_idle(input int budget);
    bit done = 0;
    out_ready = 1'b1;
    for (int n = 0; n < budget; n++) begin
      if (in_flight == 3'd0 && !out_valid && sb_q.size() == 0) begin done = 1; break; end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain: got in_flight %0d pending %0d, want 0 0", in_flight, sb_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid: got %b want 0", req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (resp_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_ready: got %b want 0", resp_ready); end
    checks++; if (in_flight !== 3'd0) begin errors++; $display("[TB] FAIL rst_in_flight: got %0d want 0", in_flight); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b want 0", err_unexp); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (resp_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_resp_ready: got %b want 1", resp_ready); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b0; req_ready = 1'b1;
    cmd_valid = 1'b1; cmd_cfu = 1'b0; cmd_func = 10'd3; cmd_data0 = 32'd5; cmd_data1 = 32'd7;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_cmd_ready: got %b want 1", cmd_ready); end
    sb_q.push_back(resp_fn(1'b0, 10'd3, 32'd5, 32'd7));
    tick();
    cmd_valid = 1'b0;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_req_valid: got %b want 1", req_valid); end
    checks++; if (req_func !== 10'd3 || req_cfu !== 1'b0) begin errors++; $display("[TB] FAIL single_req_func: got %0d/%0d want 3/0", req_func, req_cfu); end
    checks++; if (req_data0 !== 32'd5 || req_data1 !== 32'd7) begin errors++; $display("[TB] FAIL single_req_data: got %0d,%0d want 5,7", req_data0, req_data1); end
    checks++; if (in_flight !== 3'd1) begin errors++; $display("[TB] FAIL single_in_flight: got %0d want 1", in_flight); end
    tick();
    checks++; if (req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_cycle2: got req %b out %b want 0 0", req_valid, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_out_valid: got %b want 1", out_valid); end
    checks++; if (out_status !== 3'd0 || out_data !== 32'd12) begin errors++; $display("[TB] FAIL single_out: got %0d/%0d want 0/12", out_status, out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_flight !== 3'd0) begin errors++; $display("[TB] FAIL single_done: got out %b in_flight %0d want 0 0", out_valid, in_flight); end
  endtask

  task automatic test_back_to_back();
    int i = 0;
    int base = req_seen;
    out_ready = 1'b0; req_ready = 1'b1;
    for (int n = 0; n < 20 && i < 6; n++) begin
      cmd_valid = 1'b1; cmd_cfu = 1'(i); cmd_func = 10'(4 + i);
      cmd_data0 = 32'(i * 100 + 3); cmd_data1 = 32'(i + 1);
      #1;
      if (cmd_ready) begin sb_q.push_back(resp_fn(cmd_cfu, cmd_func, cmd_data0, cmd_data1)); i++; end
      tick();
    end
    checks++; if (i != 4) begin errors++; $display("[TB] FAIL b2b_accepted: got %0d want 4", i); end
    checks++; if (req_seen - base != 4) begin errors++; $display("[TB] FAIL b2b_issued: got %0d want 4", req_seen - base); end
    checks++; if (in_flight !== 3'd4 || cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full: got in_flight %0d cmd_ready %b want 4 0", in_flight, cmd_ready); end
    out_ready = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pop_ready: got %b want 1", cmd_ready); end
    if (cmd_ready) begin sb_q.push_back(resp_fn(cmd_cfu, cmd_func, cmd_data0, cmd_data1)); i++; end
    tick();
    checks++; if (in_flight !== 3'd4) begin errors++; $display("[TB] FAIL b2b_pop_and_cmd: got %0d want 4", in_flight); end
    for (int n = 0; n < 20 && i < 6; n++) begin
      cmd_valid = 1'b1; cmd_cfu = 1'(i); cmd_func = 10'(4 + i);
      cmd_data0 = 32'(i * 100 + 3); cmd_data1 = 32'(i + 1);
      #1;
      if (cmd_ready) begin sb_q.push_back(resp_fn(cmd_cfu, cmd_func, cmd_data0, cmd_data1)); i++; end
      tick();
    end
    cmd_valid = 1'b0;
    wait_idle(60);
  endtask

  task automatic test_req_stall();
    out_ready = 1'b1; req_ready = 1'b0;
    cmd_valid = 1'b1; cmd_cfu = 1'b1; cmd_func = 10'd20; cmd_data0 = 32'hA0A0; cmd_data1 = 32'h0B0B;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_first_ready: got %b want 1", cmd_ready); end
    sb_q.push_back(resp_fn(1'b1, 10'd20, 32'hA0A0, 32'h0B0B));
    tick();
    cmd_func = 10'd21; cmd_data0 = 32'h1234; cmd_data1 = 32'h5678; cmd_cfu = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_cmd_ready: got %b want 0", cmd_ready); end
      checks++;
      if (req_valid !== 1'b1 || req_func !== 10'd20 || req_data0 !== 32'hA0A0 || req_data1 !== 32'h0B0B) begin
        errors++; $display("[TB] FAIL stall_hold: got v%b f%0d %h %h want v1 f20 a0a0 0b0b", req_valid, req_func, req_data0, req_data1);
      end
      tick();
    end
    req_ready = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_ready: got %b want 1", cmd_ready); end
    sb_q.push_back(resp_fn(1'b0, 10'd21, 32'h1234, 32'h5678));
    tick();
    cmd_valid = 1'b0;
    checks++; if (req_valid !== 1'b1 || req_data0 !== 32'h1234) begin errors++; $display("[TB] FAIL stall_b2b: got v%b %h want v1 1234", req_valid, req_data0); end
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_done: got %b want 0", req_valid); end
    wait_idle(30);
  endtask

  task automatic test_clk_en();
    cfu_resp_t a;
    int seen;
    a = resp_fn(1'b0, 10'd9, 32'd77, 32'd1);
    out_ready = 1'b0; req_ready = 1'b1;
    drive_cmd(1'b0, 10'd9, 32'd77, 32'd1, 10);
    for (int n = 0; n < 10 && !out_valid; n++) tick();
    req_ready = 1'b0;
    drive_cmd(1'b1, 10'd30, 32'hCAFE, 32'h0001, 10);
    checks++; if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL clken_pending: got %b want 1", req_valid); end
    seen = req_seen;
    clk_en = 1'b0; req_ready = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (req_valid !== 1'b1 || req_data0 !== 32'hCAFE || in_flight !== 3'd2) begin
        errors++; $display("[TB] FAIL clken_freeze_req: got v%b %h in_flight %0d want v1 cafe 2", req_valid, req_data0, in_flight);
      end
      checks++;
      if (out_valid !== 1'b1 || out_status !== a.status || out_data !== a.data) begin
        errors++; $display("[TB] FAIL clken_freeze_out: got v%b %0d %h want v1 %0d %h", out_valid, out_status, out_data, a.status, a.data);
      end
    end
    checks++; if (req_seen != seen) begin errors++; $display("[TB] FAIL clken_no_issue: got %0d want %0d", req_seen, seen); end
    clk_en = 1'b1;
    tick();
    checks++; if (req_valid !== 1'b0 || in_flight !== 3'd1) begin errors++; $display("[TB] FAIL clken_resume: got v%b in_flight %0d want v0 1", req_valid, in_flight); end
    wait_idle(30);
  endtask

  task automatic test_unexpected();
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("[TB] FAIL unexp_before: got %b want 0", err_unexp); end
    man_valid = 1'b1; man_status = 3'd1; man_data = 32'hDEAD;
    tick();
    man_valid = 1'b0;
    checks++; if (err_unexp !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL unexp_set: got err %b out %b want 1 0", err_unexp, out_valid); end
    tick(); tick(); tick();
    checks++; if (err_unexp !== 1'b1 || out_valid !== 1'b0 || in_flight !== 3'd0) begin
      errors++; $display("[TB] FAIL unexp_sticky: got err %b out %b in_flight %0d want 1 0 0", err_unexp, out_valid, in_flight);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; req_ready = 1'b1;
    drive_cmd(1'b0, 10'd5, 32'd1, 32'd2, 10);
    drive_cmd(1'b1, 10'd6, 32'd3, 32'd4, 10);
    drive_cmd(1'b0, 10'd7, 32'd5, 32'd6, 10);
    checks++; if (in_flight !== 3'd3) begin errors++; $display("[TB] FAIL mid_in_flight: got %0d want 3", in_flight); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b0 || out_valid !== 1'b0 || in_flight !== 3'd0 || err_unexp !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset: got req %b out %b in_flight %0d err %b want 0 0 0 0", req_valid, out_valid, in_flight, err_unexp);
    end
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    drive_cmd(1'b1, 10'd3, 32'd40, 32'd2, 10);
    wait_idle(30);
    man_valid = 1'b1; man_status = 3'd0; man_data = 32'h1;
    tick();
    man_valid = 1'b0;
    checks++; if (err_unexp !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_late_resp: got err %b out %b want 1 0", err_unexp, out_valid); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200us, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clk_en = 1'b1;
    cmd_valid = 1'b0; cmd_cfu = 1'b0; cmd_func = '0; cmd_data0 = '0; cmd_data1 = '0;
    req_ready = 1'b1; out_ready = 1'b0;
    auto_valid = 1'b0; auto_status = '0; auto_data = '0;
    man_valid = 1'b0; man_status = '0; man_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_req_stall();
    test_clk_en();
    test_unexpected();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
